// File: rtl/mean_var_pkg.sv
// Shared types and width helpers for the mean_var_unit block statistics engine.
package mean_var_pkg;

    typedef enum logic [1:0] {StIdle, StAccum, StFinish} state_e;

    function automatic int unsigned calc_l(input int unsigned total_samples);
        return $clog2(total_samples);
    endfunction

    function automatic int unsigned sum_width(input int unsigned dw, input int unsigned l);
        return dw + l;
    endfunction

    function automatic int unsigned sumsq_width(input int unsigned dw, input int unsigned l);
        return 2 * dw + l;
    endfunction

    // Width of TOTAL_SAMPLES*sumsq - sum*sum before the final divide.
    function automatic int unsigned var_inter_width(input int unsigned dw, input int unsigned l);
        return 2 * dw + 2 * l;
    endfunction

endpackage

// File: rtl/mean_var_channel.sv
// One channel of mean_var_unit: sum/sumsq accumulators and mean/variance registers.
// Variance datapath present only when MEAN_VAR_VARIANCE_EN is defined.
module mean_var_channel
    import mean_var_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned L          = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    acc_en,
    input  logic                    finish,
    input  logic [DATA_WIDTH-1:0]   sample,
    output logic [DATA_WIDTH-1:0]   mean,
    output logic [2*DATA_WIDTH-1:0] variance
);

    localparam int unsigned SW = sum_width(DATA_WIDTH, L);

    logic [SW-1:0]         sum_q;
    logic [DATA_WIDTH-1:0] mean_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            mean_q <= '0;
        end else begin
            if (clear) begin
                sum_q <= '0;
            end else if (acc_en) begin
                sum_q <= sum_q + SW'(sample);
            end
            // Results sample the pre-clear sum, so a restart in FINISH keeps them.
            if (finish) begin
                mean_q <= sum_q[L +: DATA_WIDTH];
            end
        end
    end

    assign mean = mean_q;

`ifdef MEAN_VAR_VARIANCE_EN
    localparam int unsigned QW = sumsq_width(DATA_WIDTH, L);
    localparam int unsigned VW = var_inter_width(DATA_WIDTH, L);

    logic [QW-1:0]           sumsq_q;
    logic [2*DATA_WIDTH-1:0] var_q;
    logic [VW-1:0]           scaled;
    logic [VW-1:0]           sum_sq;
    logic [VW-1:0]           diff;

    always_comb begin
        scaled = VW'(sumsq_q) << L;
        sum_sq = VW'(sum_q) * VW'(sum_q);
        diff   = scaled - sum_sq;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sumsq_q <= '0;
            var_q   <= '0;
        end else begin
            if (clear) begin
                sumsq_q <= '0;
            end else if (acc_en) begin
                sumsq_q <= sumsq_q + QW'(sample) * QW'(sample);
            end
            if (finish) begin
                var_q <= diff[2*L +: 2*DATA_WIDTH];
            end
        end
    end

    assign variance = var_q;
`else
    assign variance = '0;
`endif

endmodule

// File: rtl/mean_var_unit.sv
// Multi-channel block mean/variance engine: shared FSM and sample counter, per-channel datapaths.
// Variance output is live only when MEAN_VAR_VARIANCE_EN is defined; otherwise tied to 0.
module mean_var_unit
    import mean_var_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned NUM_CHANNELS  = 3,
    parameter int unsigned TOTAL_SAMPLES = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start_data_in,
    input  logic                                data_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  data_in,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0]  mean_out,
    output logic [NUM_CHANNELS*2*DATA_WIDTH-1:0] var_out,
    output logic                                ready,
    output logic                                busy
);

    localparam int unsigned L = calc_l(TOTAL_SAMPLES);
    localparam logic [L-1:0] CntLast = L'(TOTAL_SAMPLES - 1);

    state_e       state_q, state_d;
    logic [L-1:0] cnt_q, cnt_d;
    logic         ready_q;
    logic         clear, acc_en, finish;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= finish;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clear   = 1'b0;
        acc_en  = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_data_in) begin
                    state_d = StAccum;
                    cnt_d   = '0;
                    clear   = 1'b1;
                end
            end
            StAccum: begin
                // Restart takes priority over a coincident sample.
                if (start_data_in) begin
                    cnt_d = '0;
                    clear = 1'b1;
                end else if (data_valid) begin
                    acc_en = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d = StFinish;
                    end
                end
            end
            StFinish: begin
                finish = 1'b1;
                cnt_d  = '0;
                if (start_data_in) begin
                    state_d = StAccum;
                    clear   = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign ready = ready_q;
    assign busy  = (state_q != StIdle);

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        mean_var_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .L          (L)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear),
            .acc_en   (acc_en),
            .finish   (finish),
            .sample   (data_in[c*DATA_WIDTH +: DATA_WIDTH]),
            .mean     (mean_out[c*DATA_WIDTH +: DATA_WIDTH]),
            .variance (var_out[c*2*DATA_WIDTH +: 2*DATA_WIDTH])
        );
    end

endmodule
